// File: rtl/piso.sv
// Serial output expander driver for a chain of 74HC595-class latching shift registers.
// Shifts a parallel word out MSB first on sdo/sclk, then strobes lat; a write during a transfer is queued.
module piso #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned CLK_DIV = 18
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             sclr,
    input  logic [WIDTH-1:0] data,
    input  logic             wr,
    output logic             sdo,
    output logic             sclk,
    output logic             lat,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q
);

    localparam int unsigned DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    state_t           r_state, w_state;
    logic [WIDTH-1:0] r_shift, w_shift;
    logic [WIDTH-1:0] r_word, w_word;
    logic             r_pend, w_pend;
    logic [WIDTH-1:0] r_pend_data, w_pend_data;
    logic [DW-1:0]    r_div, w_div;
    logic [CW-1:0]    r_bit, w_bit;
    logic             r_sdo, w_sdo;
    logic             r_sclk, w_sclk;
    logic             r_lat, w_lat;
    logic             r_busy, w_busy;
    logic             r_done, w_done;
    logic [WIDTH-1:0] r_q, w_q;

    logic             w_load;
    logic [WIDTH-1:0] w_load_word;
    logic [WIDTH-1:0] w_shl;
    logic             w_div_last;

    assign w_shl      = r_shift << 1;
    assign w_div_last = (r_div == DW'(CLK_DIV - 1));
    // A write in the same cycle as a queued word supersedes it (latest wins).
    assign w_load_word = wr ? data : r_pend_data;

    // Next-state and next-output logic.
    always_comb begin
        w_state     = r_state;
        w_shift     = r_shift;
        w_word      = r_word;
        w_pend      = r_pend;
        w_pend_data = r_pend_data;
        w_div       = r_div;
        w_bit       = r_bit;
        w_sdo       = r_sdo;
        w_sclk      = r_sclk;
        w_lat       = r_lat;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_q         = r_q;
        w_load      = 1'b0;

        if (wr && r_busy) begin
            w_pend      = 1'b1;
            w_pend_data = data;
        end

        case (r_state)
            S_IDLE: begin
                w_sclk = 1'b0;
                w_lat  = 1'b0;
                w_sdo  = 1'b0;
                if (wr || r_pend) begin
                    w_load = 1'b1;
                end
            end
            S_SHIFT: begin
                if (w_div_last) begin
                    w_div = '0;
                    if (!r_sclk) begin
                        w_sclk = 1'b1;
                    end else begin
                        // Falling sclk: only here does sdo move, giving a full phase of setup and hold.
                        w_sclk  = 1'b0;
                        w_shift = w_shl;
                        if (r_bit == '0) begin
                            w_state = S_LATCH;
                            w_sdo   = 1'b0;
                            w_lat   = 1'b1;
                        end else begin
                            w_bit = r_bit - CW'(1);
                            w_sdo = w_shl[WIDTH-1];
                        end
                    end
                end else begin
                    w_div = r_div + DW'(1);
                end
            end
            S_LATCH: begin
                w_sclk = 1'b0;
                if (w_div_last) begin
                    w_div  = '0;
                    w_lat  = 1'b0;
                    w_done = 1'b1;
                    w_q    = r_word;
                    if (wr || r_pend) begin
                        w_load = 1'b1;
                    end else begin
                        w_state = S_IDLE;
                        w_busy  = 1'b0;
                    end
                end else begin
                    w_div = r_div + DW'(1);
                end
            end
            default: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
                w_sclk  = 1'b0;
                w_lat   = 1'b0;
                w_sdo   = 1'b0;
            end
        endcase

        if (w_load) begin
            w_state = S_SHIFT;
            w_shift = w_load_word;
            w_word  = w_load_word;
            w_pend  = 1'b0;
            w_bit   = CW'(WIDTH - 1);
            w_div   = '0;
            w_sdo   = w_load_word[WIDTH-1];
            w_sclk  = 1'b0;
            w_lat   = 1'b0;
            w_busy  = 1'b1;
        end

        // Synchronous clear drops any transfer and any queued write without strobing the latch.
        if (sclr) begin
            w_state     = S_IDLE;
            w_shift     = '0;
            w_word      = '0;
            w_pend      = 1'b0;
            w_pend_data = '0;
            w_div       = '0;
            w_bit       = '0;
            w_sdo       = 1'b0;
            w_sclk      = 1'b0;
            w_lat       = 1'b0;
            w_busy      = 1'b0;
            w_done      = 1'b0;
            w_q         = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_word      <= '0;
            r_pend      <= 1'b0;
            r_pend_data <= '0;
            r_div       <= '0;
            r_bit       <= '0;
            r_sdo       <= 1'b0;
            r_sclk      <= 1'b0;
            r_lat       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_q         <= '0;
        end else begin
            r_state     <= w_state;
            r_shift     <= w_shift;
            r_word      <= w_word;
            r_pend      <= w_pend;
            r_pend_data <= w_pend_data;
            r_div       <= w_div;
            r_bit       <= w_bit;
            r_sdo       <= w_sdo;
            r_sclk      <= w_sclk;
            r_lat       <= w_lat;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_q         <= w_q;
        end
    end

    assign sdo  = r_sdo;
    assign sclk = r_sclk;
    assign lat  = r_lat;
    assign busy = r_busy;
    assign done = r_done;
    assign q    = r_q;

endmodule
